// File: rtl/reg_file_param.sv
// Parametrised register file: 2^ADDR_W x DATA_W, two async read ports, one stallable write port,
// optional hard-wired zero register and a DEPTH-cycle soft-clear sequencer. Macro: REG_FILE_BYPASS_EN.

module reg_file_param_cell #(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              wen,
  input  logic              clr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)  q <= '0;
    else if (clr)  q <= '0;
    else if (wen)  q <= d;
  end
endmodule

module reg_file_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic              BUSYWAIT,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  input  logic              CLEAR,
  output logic              CLEAR_BUSY,
  output logic              WRITE_DROPPED
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {IDLE, CLEARING} state_t;

  state_t                        state;
  logic [ADDR_W-1:0]             clr_ptr;
  logic [DEPTH-1:0][DATA_W-1:0]  regs;
  logic                          wr_req;
  logic                          zero_hit;
  logic                          commit;

  assign wr_req   = WRITE & ~BUSYWAIT;
  assign zero_hit = (ZERO_REG != 0) && (INADDRESS == '0);
  assign commit   = wr_req && (state == IDLE) && !zero_hit;

  // Sequencer: CLEAR in IDLE starts a walk over every register; CLEAR while walking is ignored.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= IDLE;
      clr_ptr       <= '0;
      CLEAR_BUSY    <= 1'b0;
      WRITE_DROPPED <= 1'b0;
    end else begin
      WRITE_DROPPED <= wr_req && (state == CLEARING);
      case (state)
        IDLE: begin
          if (CLEAR) begin
            state      <= CLEARING;
            clr_ptr    <= '0;
            CLEAR_BUSY <= 1'b1;
          end
        end
        CLEARING: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == ADDR_W'(DEPTH-1)) begin
            state      <= IDLE;
            CLEAR_BUSY <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_reg
    reg_file_param_cell #(.DATA_W(DATA_W)) u_cell (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .wen     (commit && (INADDRESS == ADDR_W'(k))),
      .clr     ((state == CLEARING) && (clr_ptr == ADDR_W'(k))),
      .d       (IN),
      .q       (regs[k])
    );
  end

  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = regs[a];
`ifdef REG_FILE_BYPASS_EN
    // Forward the in-flight write; the zero-register rule below still wins.
    if (RESET_N && commit && (a == INADDRESS)) v = IN;
`endif
    if ((ZERO_REG != 0) && (a == '0)) v = '0;
    return v;
  endfunction

  always_comb begin
    OUT1 = rd(OUT1ADDRESS);
    OUT2 = rd(OUT2ADDRESS);
  end
endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: drives an 8x8 instance and a 16x16 ZERO_REG instance
// with shared random/directed stimulus; a monitor pops model predictions and compares.

module tb_reg_file_param;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0, bw = 1'b0, clr = 1'b0;
  logic [3:0]  wa = '0, ra1 = '0, ra2 = '0;
  logic [15:0] din = '0;

  logic [7:0]  a_o1, a_o2;
  logic [15:0] b_o1, b_o2;
  logic        a_busy, a_drop, b_busy, b_drop;

  always #5 clk = ~clk;

  reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) u_a (
    .CLK(clk), .RESET_N(rst_n), .IN(din[7:0]), .INADDRESS(wa[2:0]), .WRITE(we),
    .BUSYWAIT(bw), .OUT1ADDRESS(ra1[2:0]), .OUT2ADDRESS(ra2[2:0]), .OUT1(a_o1),
    .OUT2(a_o2), .CLEAR(clr), .CLEAR_BUSY(a_busy), .WRITE_DROPPED(a_drop)
  );

  reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) u_b (
    .CLK(clk), .RESET_N(rst_n), .IN(din), .INADDRESS(wa), .WRITE(we),
    .BUSYWAIT(bw), .OUT1ADDRESS(ra1), .OUT2ADDRESS(ra2), .OUT1(b_o1),
    .OUT2(b_o2), .CLEAR(clr), .CLEAR_BUSY(b_busy), .WRITE_DROPPED(b_drop)
  );

  typedef struct packed {
    logic [1:0][15:0] o1;
    logic [1:0][15:0] o2;
    logic [1:0]       busy;
    logic [1:0]       drop;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model: contents, cycles of clear remaining, pending drop flag.
  logic [15:0] mem [2][16];
  int          left [2];
  bit          drp  [2];
  int          depth [2] = '{8, 16};
  bit          zr    [2] = '{1'b0, 1'b1};

  function automatic logic [3:0] amask(input int i, input logic [3:0] a);
    return (i == 0) ? {1'b0, a[2:0]} : a;
  endfunction

  function automatic logic [15:0] dmask(input int i, input logic [15:0] d);
    return (i == 0) ? {8'h00, d[7:0]} : d;
  endfunction

  function automatic bit commits(input int i);
    return we && !bw && left[i] == 0 && !(zr[i] && amask(i, wa) == 0);
  endfunction

  function automatic logic [15:0] predict(input int i, input logic [3:0] a);
    logic [3:0] am;
    am = amask(i, a);
    if (zr[i] && am == 0) return 16'h0;
`ifdef REG_FILE_BYPASS_EN
    if (rst_n && commits(i) && am == amask(i, wa)) return dmask(i, din);
`endif
    return mem[i][am];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 16; k++) mem[i][k] = '0;
      left[i] = 0;
      drp[i]  = 1'b0;
    end
  endtask

  // Effect of one rising edge given the inputs held across it.
  task automatic model_edge();
    if (!rst_n) return;
    for (int i = 0; i < 2; i++) begin
      if (left[i] > 0) begin
        drp[i] = we && !bw;
        mem[i][depth[i] - left[i]] = '0;
        left[i]--;
      end else begin
        drp[i] = 1'b0;
        if (commits(i)) mem[i][amask(i, wa)] = dmask(i, din);
        if (clr) left[i] = depth[i];
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      e.o1[i]   = predict(i, ra1);
      e.o2[i]   = predict(i, ra2);
      e.busy[i] = left[i] > 0;
      e.drop[i] = drp[i];
    end
    q.push_back(e);
  endtask

  task automatic step(input logic w, b, c, input logic [3:0] a, input logic [15:0] d,
                      input logic [3:0] r1, r2);
    @(posedge clk);
    model_edge();
    #1;
    rst_n = 1'b1;
    we = w; bw = b; clr = c; wa = a; din = d; ra1 = r1; ra2 = r2;
    push_exp();
  endtask

  // Asynchronous reset asserted mid-cycle; released by the next step.
  task automatic do_reset(input logic [3:0] r1, r2);
    @(posedge clk);
    model_edge();
    #1;
    we = 0; bw = 0; clr = 0; ra1 = r1; ra2 = r2;
    rst_n = 1'b0;
    model_reset();
    push_exp();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      step(0, 0, 0, 0, 0, 4'($urandom), 4'($urandom));
  endtask

  task automatic cmp(input string name, input int i, input logic [15:0] got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t got %h expected %h", name, i, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp("out1", 0, {8'h0, a_o1}, e.o1[0]);
      cmp("out2", 0, {8'h0, a_o2}, e.o2[0]);
      cmp("clear_busy", 0, {15'h0, a_busy}, {15'h0, e.busy[0]});
      cmp("write_dropped", 0, {15'h0, a_drop}, {15'h0, e.drop[0]});
      cmp("out1", 1, b_o1, e.o1[1]);
      cmp("out2", 1, b_o2, e.o2[1]);
      cmp("clear_busy", 1, {15'h0, b_busy}, {15'h0, e.busy[1]});
      cmp("write_dropped", 1, {15'h0, b_drop}, {15'h0, e.drop[1]});
    end
  end

  initial begin
    model_reset();
    do_reset(0, 1);
    // Basic writes and readback
    step(1, 0, 0, 3, 16'h00A5, 0, 1);
    step(1, 0, 0, 5, 16'h003C, 3, 5);
    step(0, 0, 0, 0, 0, 5, 3);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 2, 2);
    // Stalled write is held off, never flagged
    repeat (3) step(1, 1, 0, 2, 16'h00FF, 2, 2);
    step(1, 0, 0, 2, 16'h00FF, 2, 2);
    step(0, 0, 0, 0, 0, 2, 2);
    // Fill, then clear with a write landing mid-clear
    for (int k = 0; k < 16; k++) step(1, 0, 0, 4'(k), 16'(k * 16'h1111 + 1), 4'(k), 7);
    step(0, 0, 1, 0, 0, 0, 7);
    step(0, 0, 0, 0, 0, 1, 7);
    step(1, 0, 0, 7, 16'h0011, 7, 2);
    for (int k = 0; k < 20; k++) step(0, 0, 0, 0, 0, 4'(k), 4'(15 - k));
    // Write and clear in the same cycle
    step(1, 0, 1, 6, 16'h0099, 6, 6);
    idle(20);
    // Reset in the middle of a clear, then a full clear afterwards
    for (int k = 0; k < 8; k++) step(1, 0, 0, 4'(k), 16'h1234 + 16'(k), 4'(k), 1);
    step(0, 0, 1, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0, 3, 4);
    do_reset(1, 3);
    step(1, 0, 0, 1, 16'h0042, 1, 1);
    step(0, 0, 1, 0, 0, 1, 1);
    idle(20);
    // Zero register, top register of the wide instance, same-cycle read of a write
    step(1, 0, 0, 0, 16'h0077, 0, 0);
    step(1, 0, 0, 15, 16'hBEEF, 0, 15);
    step(0, 0, 0, 0, 0, 15, 7);
    step(1, 0, 0, 4, 16'h005A, 3, 4);
    step(0, 0, 0, 0, 0, 4, 4);
    // Random traffic
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset(4'($urandom), 4'($urandom));
      else step($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                $urandom_range(0, 39) == 0, 4'($urandom), 16'($urandom),
                4'($urandom), 4'($urandom));
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
